// File: rtl/memory_island_bank_arbiter.sv
// Round-robin arbiter sharing one SRAM bank port among several requesters.
// Accepted accesses are tracked through a fixed-latency pipeline so each
// bank response is steered back to the requester that issued it.
module memory_island_bank_arbiter #(
  parameter int unsigned NumReq     = 4,
  parameter int unsigned AddrWidth  = 32,
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned MemLatency = 1
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NumReq-1:0]                     req_i,
  output logic [NumReq-1:0]                     gnt_o,
  input  logic [NumReq-1:0][AddrWidth-1:0]      addr_i,
  input  logic [NumReq-1:0]                     we_i,
  input  logic [NumReq-1:0][DataWidth-1:0]      wdata_i,
  input  logic [NumReq-1:0][DataWidth/8-1:0]    strb_i,
  output logic [NumReq-1:0]                     rvalid_o,
  output logic [DataWidth-1:0]                  rdata_o,
  output logic                                  mem_req_o,
  input  logic                                  mem_gnt_i,
  output logic [AddrWidth-1:0]                  mem_addr_o,
  output logic                                  mem_we_o,
  output logic [DataWidth-1:0]                  mem_wdata_o,
  output logic [DataWidth/8-1:0]                mem_strb_o,
  input  logic [DataWidth-1:0]                  mem_rdata_i
);

  localparam int unsigned IdxWidth  = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned LastStage = MemLatency - 1;

  logic [IdxWidth-1:0]                 rr_q;
  logic [IdxWidth-1:0]                 rr_d;
  logic [IdxWidth-1:0]                 winner_c;
  logic [IdxWidth-1:0]                 cand_c;
  logic                                accept_c;
  logic [MemLatency-1:0]               pipe_vld_q;
  logic [MemLatency-1:0][IdxWidth-1:0] pipe_idx_q;

  // Winner search: scan offsets from farthest to nearest so the nearest
  // requesting index (starting at rr_q) is the last one written.
  always_comb begin
    winner_c = rr_q;
    cand_c   = rr_q;
    for (int unsigned k = 0; k < NumReq; k++) begin
      cand_c = IdxWidth'((32'(rr_q) + NumReq - 1 - k) % NumReq);
      if (req_i[cand_c]) begin
        winner_c = cand_c;
      end
    end
  end

  assign mem_req_o   = (|req_i) & ~rst_i;
  assign accept_c    = mem_req_o & mem_gnt_i;
  assign mem_addr_o  = addr_i[winner_c];
  assign mem_we_o    = we_i[winner_c];
  assign mem_wdata_o = wdata_i[winner_c];
  assign mem_strb_o  = strb_i[winner_c];
  assign rdata_o     = mem_rdata_i;

  // Pointer moves just past the winner, wrapping at the last requester.
  assign rr_d = (32'(winner_c) == NumReq - 1) ? '0 : winner_c + IdxWidth'(1);

  // Grant only the winner, and only when the bank takes the access.
  always_comb begin
    gnt_o = '0;
    if (accept_c) begin
      gnt_o[winner_c] = 1'b1;
    end
  end

  // Round-robin pointer and response-tracking pipeline (never stalls).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q       <= '0;
      pipe_vld_q <= '0;
      pipe_idx_q <= '0;
    end else begin
      if (accept_c) begin
        rr_q <= rr_d;
      end
      pipe_vld_q[0] <= accept_c;
      pipe_idx_q[0] <= winner_c;
      for (int unsigned s = 1; s < MemLatency; s++) begin
        pipe_vld_q[s] <= pipe_vld_q[s-1];
        pipe_idx_q[s] <= pipe_idx_q[s-1];
      end
    end
  end

  // Response valid is routed to the requester recorded in the last stage.
  always_comb begin
    rvalid_o = '0;
    if (pipe_vld_q[LastStage] && !rst_i) begin
      rvalid_o[pipe_idx_q[LastStage]] = 1'b1;
    end
  end

endmodule
